adder_vector_sequencer: RTL
===========================

// Module: adder_vector_sequencer
// PURPOSE
// - Upstream stimulus/downstream check stage for the 4-bit ripple Adder (ai,bi,ci -> s,cout).
// - Generates operand vectors {ai,bi,ci} from a 9-bit LFSR and drives them into the adder.
// - Samples {cout,s} after a settle window, compares against an internal golden sum, and counts errors.
// - Replaces free-running $random stimulus with a clocked, repeatable, self-checking sequence.
// PARAMETERS
// - NUM_VECTORS    default 32      vectors per run, 1..255
// - SETTLE_CYCLES  default 1       cycles operands held before sampling, 1..15
// - SEED           default 9'h1A5  LFSR seed, {ai,bi,ci}; 9'h000 is replaced by 9'h001
// PORTS
// - clk            in   1  rising-edge clock
// - rst            in   1  asynchronous, active-high reset
// - start          in   1  begin run; sampled in IDLE/DONE only
// - s              in   4  adder sum
// - cout           in   1  adder carry out
// - ai             out  4  operand A to adder
// - bi             out  4  operand B to adder
// - ci             out  1  carry in to adder
// - busy           out  1  run in progress (DRIVE or CHECK)
// - done           out  1  run complete; held until next start or reset
// - pass           out  1  done && err_cnt==0
// - err_cnt        out  8  mismatch count, saturates at 255
// - first_err_vec  out  9  {ai,bi,ci} of first mismatch; 0 if none
// BEHAVIOUR
// - Reset (async): state=IDLE; ai,bi,ci,err_cnt,first_err_vec,busy,done,pass = 0; lfsr=SEED.
// - LFSR: 9-bit Fibonacci, x^9+x^5+1, next = {lfsr[7:0], lfsr[8]^lfsr[4]}; never zero.
// - FSM IDLE: start=1 -> load {ai,bi,ci}=lfsr(seed), vec_cnt=0, err_cnt=0, first_err_vec=0, settle=0 -> DRIVE.
// - FSM DRIVE: operands held constant; settle++ each cycle; settle==SETTLE_CYCLES-1 -> CHECK.
// - FSM CHECK: golden = ai+bi+ci (5-bit, zero-extended); mismatch if {cout,s}!=golden.
//   - mismatch: err_cnt++ (hold at 255); if err_cnt==0, first_err_vec={ai,bi,ci}.
//   - vec_cnt==NUM_VECTORS-1 -> DONE; else advance lfsr, load new operands, settle=0 -> DRIVE.
// - FSM DONE: done=1, pass=(err_cnt==0), operands hold last vector; start=1 -> same as IDLE start
//   (LFSR continues from current state, not reseeded; reseed only by reset).
// - busy=1 in DRIVE/CHECK; start while busy is ignored.
// - Timing: each vector occupies SETTLE_CYCLES+1 cycles; done rises NUM_VECTORS*(SETTLE_CYCLES+1)
//   cycles after the edge that samples start.
// - Adder is combinational; s/cout are sampled only in CHECK, never in DRIVE.
// - rst mid-run: immediate return to reset values; no partial done/pass.
// - All outputs registered; no combinational path from s/cout to outputs.
// CONFIGURATION
// - ADDER_EXHAUSTIVE_EN defined: LFSR replaced by 9-bit up-counter starting at 0, +1 per vector,
//   wraps 511->0; vector count fixed at 512 (NUM_VECTORS ignored); SEED ignored; covers every
//   {ai,bi,ci} exactly once per run; vec_cnt widened to 10 bits.
// - ADDER_EXHAUSTIVE_EN undefined: LFSR sequencing as above.
// TESTING
// - Correct Adder, defaults, pulse start -> busy 64 cycles, done=1, pass=1, err_cnt=0, first_err_vec=0.
// - Adder with s[0] forced 0 -> done=1, pass=0, err_cnt>0; first_err_vec = first vector whose golden[0]=1.
// - SEED=0 -> first vector is 9'h001 (ai=0,bi=0,ci=1), golden=5'h01; run completes normally.
// - start held high during run, then rst at cycle 10 of run -> start ignored while busy;
//   after rst, all outputs 0, state IDLE.
// - Model returns {cout,s}=5'h1F always; NUM_VECTORS=255 and ~all mismatch -> err_cnt saturates at 255, no wrap.
// - ADDER_EXHAUSTIVE_EN, SETTLE_CYCLES=1 -> 1024 busy cycles; last vector {ai,bi,ci}=9'h1FF
//   (15+15+1 = 5'h1F); pass=1.

Source files
------------

// File: rtl/adder_vector_sequencer.sv
// Clocked stimulus/check stage for a 4-bit ripple adder: drives {ai,bi,ci} from a 9-bit LFSR and counts mismatches.
// Define ADDER_EXHAUSTIVE_EN to replace the LFSR with a 512-vector exhaustive up-counter sweep.
module adder_vector_sequencer #(
  parameter int         NUM_VECTORS   = 32,
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [8:0] SEED          = 9'h1A5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] s,
  input  logic       cout,
  output logic [3:0] ai,
  output logic [3:0] bi,
  output logic       ci,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [8:0] first_err_vec
);

`ifdef ADDER_EXHAUSTIVE_EN
  localparam int         VW       = 10;
  localparam logic [9:0] LAST_VEC = 10'd511;
  localparam logic [8:0] GEN_INIT = 9'h000;
`else
  localparam int         VW       = 8;
  localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);
  localparam logic [8:0] GEN_INIT = (SEED == 9'h000) ? 9'h001 : SEED;
`endif
  localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t        state;
  logic [8:0]    gen;
  logic [VW-1:0] vec_cnt;
  logic [3:0]    settle;

  logic [4:0]    golden;
  logic          mismatch;
  logic [8:0]    gen_adv;
  logic [7:0]    err_nxt;

  function automatic logic [8:0] gen_next(input logic [8:0] x);
`ifdef ADDER_EXHAUSTIVE_EN
    return x + 9'd1;
`else
    return {x[7:0], x[8] ^ x[4]};
`endif
  endfunction

  assign golden   = {1'b0, ai} + {1'b0, bi} + {4'b0000, ci};
  assign mismatch = ({cout, s} != golden);
  assign gen_adv  = gen_next(gen);
  assign err_nxt  = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      gen           <= GEN_INIT;
      vec_cnt       <= '0;
      settle        <= '0;
      ai            <= '0;
      bi            <= '0;
      ci            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            {ai, bi, ci}  <= gen;
            vec_cnt       <= '0;
            settle        <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            state         <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle == LAST_SETTLE) state <= CHECK;
          else                       settle <= settle + 4'd1;
        end
        CHECK: begin
          err_cnt <= err_nxt;
          if (mismatch && (err_cnt == 8'h00)) first_err_vec <= {ai, bi, ci};
          // The generator always steps past the last vector so a restart from DONE continues the sequence.
          gen <= gen_adv;
          if (vec_cnt == LAST_VEC) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 8'h00);
            state <= DONE;
          end else begin
            {ai, bi, ci} <= gen_adv;
            vec_cnt      <= vec_cnt + 1'b1;
            settle       <= '0;
            state        <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
